// File: rtl/demux_16b_4output_buf_pkg.sv
// Shared definitions for the one-to-four registered distributor: default
// widths, destination codes (the same codes the four-input selector uses
// for its Op, so both blocks stay symmetric) and the slot state encoding.
package demux_16b_4output_buf_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = 16;

    localparam logic [1:0] DST_A = 2'd0;
    localparam logic [1:0] DST_B = 2'd1;
    localparam logic [1:0] DST_C = 2'd2;
    localparam logic [1:0] DST_D = 2'd3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // One-hot slot select for a destination code.
    function automatic logic [3:0] dst_onehot(input logic [1:0] op);
        return 4'b0001 << op;
    endfunction

endpackage

// File: rtl/demux_16b_4output_buf_if.sv
// Bus bundle for the distributor: the source side (In/Op/In_Valid/In_Ready),
// the four consumer slots (Out_x/Valid_x/Ready_x) and the accept counter.
// master = source and consumers; slave = the distributor itself.
interface demux_16b_4output_buf_if
    import demux_16b_4output_buf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic [WIDTH-1:0] In;
    logic [1:0]       Op;
    logic             In_Valid;
    logic             In_Ready;

    logic [WIDTH-1:0] Out_A;
    logic [WIDTH-1:0] Out_B;
    logic [WIDTH-1:0] Out_C;
    logic [WIDTH-1:0] Out_D;

    logic             Valid_A;
    logic             Valid_B;
    logic             Valid_C;
    logic             Valid_D;

    logic             Ready_A;
    logic             Ready_B;
    logic             Ready_C;
    logic             Ready_D;

    logic [CNT_W-1:0] Accept_Count;

    modport master (
        output In, Op, In_Valid,
        output Ready_A, Ready_B, Ready_C, Ready_D,
        input  In_Ready,
        input  Out_A, Out_B, Out_C, Out_D,
        input  Valid_A, Valid_B, Valid_C, Valid_D,
        input  Accept_Count
    );

    modport slave (
        input  In, Op, In_Valid,
        input  Ready_A, Ready_B, Ready_C, Ready_D,
        output In_Ready,
        output Out_A, Out_B, Out_C, Out_D,
        output Valid_A, Valid_B, Valid_C, Valid_D,
        output Accept_Count
    );

endinterface

// File: rtl/demux_16b_4output_buf_slot.sv
// Single-entry holding slot. A load always wins: a full slot that drains and
// loads in the same cycle stays FULL with the new word, so a consumer that
// keeps ready high sees one word per cycle with valid never dropping.
module demux_slot_16b
    import demux_16b_4output_buf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_accept
);

    slot_state_t      state_q;
    slot_state_t      state_d;
    logic [WIDTH-1:0] data_q;

    // Slot state register; reset discards any held word.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data register only moves on a load to this slot.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    // Next state and handshake outputs; ready on an empty slot is ignored.
    always_comb begin
        state_d    = state_q;
        valid      = 1'b0;
        can_accept = 1'b1;
        case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                valid      = 1'b1;
                can_accept = ready;
                if (!load && ready) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign data = data_q;

endmodule

// File: rtl/demux_16b_4output_buf.sv
// One-to-four registered distributor. Decodes Op into a one-hot load, selects
// In_Ready from the addressed slot only, and counts accepted words (wrapping).
module demux_16b_4output_buf
    import demux_16b_4output_buf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                     CLK,
    input  logic                     Reset_n,
    demux_16b_4output_buf_if.slave   bus
);

    logic [3:0]       load;
    logic [3:0]       ready;
    logic [3:0]       valid;
    logic [3:0]       can_accept;
    logic [WIDTH-1:0] data [4];
    logic             accept;
    logic [CNT_W-1:0] count_q;

    assign ready    = {bus.Ready_D, bus.Ready_C, bus.Ready_B, bus.Ready_A};
    assign bus.In_Ready = can_accept[bus.Op];
    assign accept   = bus.In_Valid & bus.In_Ready;
    assign load     = accept ? dst_onehot(bus.Op) : 4'b0000;

    for (genvar i = 0; i < 4; i++) begin : g_slot
        demux_slot_16b #(
            .WIDTH      (WIDTH)
        ) u_slot (
            .CLK        (CLK),
            .Reset_n    (Reset_n),
            .load       (load[i]),
            .load_data  (bus.In),
            .ready      (ready[i]),
            .valid      (valid[i]),
            .data       (data[i]),
            .can_accept (can_accept[i])
        );
    end

    assign bus.Out_A   = data[DST_A];
    assign bus.Out_B   = data[DST_B];
    assign bus.Out_C   = data[DST_C];
    assign bus.Out_D   = data[DST_D];
    assign bus.Valid_A = valid[DST_A];
    assign bus.Valid_B = valid[DST_B];
    assign bus.Valid_C = valid[DST_C];
    assign bus.Valid_D = valid[DST_D];

    // Accepted-word counter, free-running wrap with no saturation.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.Accept_Count = count_q;

endmodule

// File: tb/tb_demux_16b_4output_buf.sv
// Bench for the one-to-four distributor: directed scenarios with literal
// expectations, a randomized phase checked every cycle against a slot model,
// and a counter-wrap run on a second instance with a 4-bit counter.
module tb_demux_16b_4output_buf;

    logic CLK;
    logic Reset_n;

    int total = 0;
    int bad   = 0;

    demux_16b_4output_buf_if #(.WIDTH(16), .CNT_W(16)) bus ();
    demux_16b_4output_buf_if #(.WIDTH(16), .CNT_W(4))  bus2 ();

    demux_16b_4output_buf #(.WIDTH(16), .CNT_W(16)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    demux_16b_4output_buf #(.WIDTH(16), .CNT_W(4)) dut2 (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model: each slot is a full flag plus a word.
    logic        m_full [4];
    logic [15:0] m_data [4];
    logic [15:0] m_cnt;
    logic [3:0]  m_rdy;
    logic        m_acc;

    // Generic comparison; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive the source and consumers just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [15:0] d, input logic [3:0] rdy);
        @(posedge CLK);
        #2;
        bus.In_Valid = v;
        bus.Op       = op;
        bus.In       = d;
        {bus.Ready_D, bus.Ready_C, bus.Ready_B, bus.Ready_A} = rdy;
    endtask

    // Model update: drains first, then the accept (which may refill a drained slot).
    always @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_full[i] = 1'b0;
                m_data[i] = 16'h0000;
            end
            m_cnt = 16'h0000;
        end else begin
            m_rdy = {bus.Ready_D, bus.Ready_C, bus.Ready_B, bus.Ready_A};
            m_acc = bus.In_Valid && (!m_full[bus.Op] || m_rdy[bus.Op]);
            for (int i = 0; i < 4; i++) begin
                if (m_full[i] && m_rdy[i]) m_full[i] = 1'b0;
            end
            if (m_acc) begin
                m_full[bus.Op] = 1'b1;
                m_data[bus.Op] = bus.In;
                m_cnt          = m_cnt + 16'd1;
            end
        end
    end

    // Every-cycle comparison of the main instance against the model.
    always @(negedge CLK) begin
        logic [3:0] rdy_now;
        if (Reset_n === 1'b1) begin
            rdy_now = {bus.Ready_D, bus.Ready_C, bus.Ready_B, bus.Ready_A};
            checkOutput("model_valid_a", 32'(bus.Valid_A), 32'(m_full[0]));
            checkOutput("model_valid_b", 32'(bus.Valid_B), 32'(m_full[1]));
            checkOutput("model_valid_c", 32'(bus.Valid_C), 32'(m_full[2]));
            checkOutput("model_valid_d", 32'(bus.Valid_D), 32'(m_full[3]));
            checkOutput("model_out_a", 32'(bus.Out_A), 32'(m_data[0]));
            checkOutput("model_out_b", 32'(bus.Out_B), 32'(m_data[1]));
            checkOutput("model_out_c", 32'(bus.Out_C), 32'(m_data[2]));
            checkOutput("model_out_d", 32'(bus.Out_D), 32'(m_data[3]));
            checkOutput("model_count", 32'(bus.Accept_Count), 32'(m_cnt));
            checkOutput("model_in_ready", 32'(bus.In_Ready),
                        32'(!m_full[bus.Op] || rdy_now[bus.Op]));
        end
    end

    logic [15:0] stream [4];

    initial begin
        Reset_n      = 1'b0;
        bus.In_Valid = 1'b0;
        bus.Op       = 2'd0;
        bus.In       = 16'h0000;
        {bus.Ready_D, bus.Ready_C, bus.Ready_B, bus.Ready_A} = 4'b0000;
        bus2.In_Valid = 1'b0;
        bus2.Op       = 2'd0;
        bus2.In       = 16'h0000;
        {bus2.Ready_D, bus2.Ready_C, bus2.Ready_B, bus2.Ready_A} = 4'b1111;

        #1;
        checkOutput("reset_count", 32'(bus.Accept_Count), 32'h0);
        checkOutput("reset_valid_a", 32'(bus.Valid_A), 32'h0);
        repeat (2) @(posedge CLK);
        #2 Reset_n = 1'b1;

        // Mid-cycle reset with slot B holding 0xBEEF.
        applyStimulus(1'b1, 2'd1, 16'hBEEF, 4'b0000);
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0000);
        #1;
        checkOutput("preload_valid_b", 32'(bus.Valid_B), 32'h1);
        checkOutput("preload_out_b", 32'(bus.Out_B), 32'hBEEF);
        #3 Reset_n = 1'b0;
        #1;
        checkOutput("async_valid_b", 32'(bus.Valid_B), 32'h0);
        checkOutput("async_out_b", 32'(bus.Out_B), 32'h0);
        checkOutput("async_count", 32'(bus.Accept_Count), 32'h0);
        @(posedge CLK);
        #2 Reset_n = 1'b1;

        // Basic steering to slot C.
        applyStimulus(1'b1, 2'd2, 16'h1234, 4'b0000);
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0000);
        #1;
        checkOutput("steer_valid_c", 32'(bus.Valid_C), 32'h1);
        checkOutput("steer_out_c", 32'(bus.Out_C), 32'h1234);
        checkOutput("steer_valid_abd", 32'({bus.Valid_A, bus.Valid_B, bus.Valid_D}), 32'h0);
        checkOutput("steer_count", 32'(bus.Accept_Count), 32'h1);

        // Backpressure on slot A.
        applyStimulus(1'b1, 2'd0, 16'h00AA, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'd0, 16'h5555, 4'b0000);
            #1;
            checkOutput("bp_in_ready", 32'(bus.In_Ready), 32'h0);
            checkOutput("bp_out_a", 32'(bus.Out_A), 32'h00AA);
            checkOutput("bp_count", 32'(bus.Accept_Count), 32'h2);
        end
        applyStimulus(1'b1, 2'd0, 16'h5555, 4'b0001);
        #1;
        checkOutput("bp_release_ready", 32'(bus.In_Ready), 32'h1);
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0000);
        #1;
        checkOutput("bp_out_a_new", 32'(bus.Out_A), 32'h5555);
        checkOutput("bp_valid_a", 32'(bus.Valid_A), 32'h1);
        checkOutput("bp_count_new", 32'(bus.Accept_Count), 32'h3);

        // Drain and refill slot D every cycle.
        stream[0] = 16'h0002;
        stream[1] = 16'h0003;
        stream[2] = 16'h0004;
        stream[3] = 16'h0000;
        applyStimulus(1'b1, 2'd3, 16'h0001, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i < 3, 2'd3, stream[i], 4'b1000);
            #1;
            checkOutput("stream_out_d", 32'(bus.Out_D), 32'(i + 1));
            checkOutput("stream_valid_d", 32'(bus.Valid_D), 32'h1);
            if (i < 3) checkOutput("stream_in_ready", 32'(bus.In_Ready), 32'h1);
        end
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0000);
        #1;
        checkOutput("stream_drained", 32'(bus.Valid_D), 32'h0);
        checkOutput("stream_count", 32'(bus.Accept_Count), 32'h7);

        // Cross-slot independence: A full and stalled, write B.
        applyStimulus(1'b1, 2'd1, 16'h7777, 4'b0000);
        #1;
        checkOutput("cross_in_ready", 32'(bus.In_Ready), 32'h1);
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0000);
        #1;
        checkOutput("cross_out_b", 32'(bus.Out_B), 32'h7777);
        checkOutput("cross_out_a", 32'(bus.Out_A), 32'h5555);
        checkOutput("cross_valid_a", 32'(bus.Valid_A), 32'h1);

        // Randomized traffic, with one asynchronous reset in the middle.
        for (int n = 0; n < 800; n++) begin
            applyStimulus($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 16'($urandom),
                          {$urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                           $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6});
            if (n == 400) begin
                #4 Reset_n = 1'b0;
                #1;
                checkOutput("rand_reset_valid", 32'({bus.Valid_A, bus.Valid_B, bus.Valid_C, bus.Valid_D}), 32'h0);
                checkOutput("rand_reset_count", 32'(bus.Accept_Count), 32'h0);
                @(posedge CLK);
                #2 Reset_n = 1'b1;
            end
        end
        applyStimulus(1'b0, 2'd0, 16'h0000, 4'b0000);

        // Counter wrap on the 4-bit instance: one accept per cycle.
        @(posedge CLK);
        #2;
        checkOutput("wrap_start", 32'(bus2.Accept_Count), 32'h0);
        bus2.In_Valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge CLK);
            #2;
            if (i == 15) checkOutput("wrap_15", 32'(bus2.Accept_Count), 32'hF);
            if (i == 16) checkOutput("wrap_16", 32'(bus2.Accept_Count), 32'h0);
            if (i == 17) checkOutput("wrap_17", 32'(bus2.Accept_Count), 32'h1);
            bus2.Op = 2'($urandom_range(0, 3));
            bus2.In = 16'($urandom);
        end
        bus2.In_Valid = 1'b0;

        repeat (2) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_16b_4output_buf.md
Name: demux_16b_4output_buf

Overview:
- One-to-four registered distributor: the write-side counterpart of the datapath's 16-bit four-input selector.
- Accepts one 16-bit word per cycle with a 2-bit destination code (Op). Steers the word into one of four single-entry output slots.
- Each slot presents the word to its consumer with a valid/ready handshake.
- Sits between the accumulator/ALU result bus and four independent write-back consumers (register file, memory write port, I/O, PC load).

Parameters:
- WIDTH, 16, data width of In and each Out_x.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- In  input  WIDTH  source word.
- Op  input  2  destination code: 0→A, 1→B, 2→C, 3→D.
- In_Valid  input  1  source presents In/Op this cycle.
- In_Ready  output  1  block accepts In/Op this cycle.
- Out_A, Out_B, Out_C, Out_D  output  WIDTH  slot data.
- Valid_A, Valid_B, Valid_C, Valid_D  output  1  slot holds an undelivered word.
- Ready_A, Ready_B, Ready_C, Ready_D  input  1  consumer takes the slot word this cycle.
- Accept_Count  output  CNT_W  number of words accepted since reset.

Behaviour:
- Reset (Reset_n low, asynchronous, any time):
  - All slots go EMPTY; all Valid_x = 0; all Out_x = 0; Accept_Count = 0.
  - Words held in slots or mid-handshake are discarded, not delivered.
  - Release is synchronous to CLK.
- Per-slot state machine, states EMPTY and FULL:
  - EMPTY→FULL: accept to this slot.
  - FULL→EMPTY: drain (Valid_x & Ready_x) with no accept to this slot in the same cycle.
  - FULL→FULL: drain and accept to this slot in the same cycle. The slot reloads with the new word and Valid_x stays 1.
  - FULL→FULL: no drain. Data is held stable.
- Outputs:
  - Valid_x = (slot x FULL).
  - Out_x = slot data register. It changes only on an accept to slot x; it is never affected by accepts to other slots.
- In_Ready = slot[Op] EMPTY, or (slot[Op] FULL and Ready of slot[Op] high).
  - Combinational from Op, slot state and Ready_x; no dependency on In_Valid.
  - Ready_x of non-selected slots does not affect In_Ready.
- Accept = In_Valid & In_Ready. On accept:
  - slot[Op] data ← In;
  - slot[Op] state ← FULL;
  - Accept_Count ← Accept_Count + 1.
- Latency: a word accepted at edge N is visible on Out_x with Valid_x = 1 after edge N.
- Throughput: one word per cycle when consumers keep Ready high, including back-to-back words to the same slot.
- Independent drains: any number of slots may drain in the same cycle as an accept to another slot.
- Ready_x while Valid_x = 0 has no effect.
- Accept_Count wraps from 2^CNT_W−1 to 0. No saturation and no flag.
- In_Valid low: no state change other than drains.
- In, Op and In_Valid are don't-care when In_Valid is low.

Decomposition:
- Shared package: WIDTH default, destination codes DST_A=2'd0, DST_B=2'd1, DST_C=2'd2, DST_D=2'd3, slot state encoding EMPTY=1'b0, FULL=1'b1.
- Use these same destination codes for Op on the four-input selector so the two blocks stay symmetric.
- One natural sub-module: demux_slot_16b, a single-entry holding slot.
  - Inputs: load, load data, Ready.
  - Outputs: Valid, data, can_accept.
  - Instantiated four times.
- The top level holds the Op decode, the In_Ready select and Accept_Count.

Test Plan:
- Reset values: assert Reset_n=0 mid-cycle with slot B FULL (0xBEEF) → Valid_B=0, Out_B=0x0000, Accept_Count=0 immediately, before the next edge.
- Basic steering: In=0x1234, Op=2, In_Valid=1 for one cycle, all Ready=0 → after edge, Valid_C=1, Out_C=0x1234, Valid_A/B/D=0, Accept_Count=1.
- Backpressure: slot A FULL (0x00AA), Ready_A=0, In=0x5555, Op=0, In_Valid=1 → In_Ready=0, Out_A stays 0x00AA for 5 cycles, Accept_Count unchanged.
  - Then raise Ready_A → In_Ready=1; after edge, Out_A=0x5555, Valid_A=1.
- Simultaneous drain+refill: slot D FULL (0x0001), Ready_D=1, stream 0x0002, 0x0003, 0x0004 to Op=3 on consecutive cycles → one word per cycle, consumer sees 0x0001, 0x0002, 0x0003, 0x0004 in order, Valid_D never drops.
- Cross-slot independence: slot A FULL with Ready_A=0; send 0x7777 to Op=1 → In_Ready=1, Out_B=0x7777; Out_A and Valid_A unchanged.
- Counter wrap: with CNT_W=4, accept 17 words → Accept_Count reads 0xF after 15 accepts, 0x0 after 16, 0x1 after 17.
